alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 145 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: one-cycle ops, bit-serial shifts.
// Define ALU_BARREL_SHIFT_EN to replace the serial shifter with a barrel shifter.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cond
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_BGE  = 4'hC;
  localparam logic [3:0] OP_BGEU = 4'hD;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state, state_next;
  logic            accept;
  logic            shift_start;
  logic [4:0]      shamt;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic            alu_cond;

  assign shamt  = op_b[4:0];
  assign lt_s   = $signed(op_a) < $signed(op_b);
  assign lt_u   = op_a < op_b;
  assign eq     = op_a == op_b;
  assign accept = in_valid && in_ready;

  // Single-cycle result; in serial builds shift codes only reach here with amount 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    alu_res  = '0;
    alu_cond = 1'b0;
    case (alu_ctrl)
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  begin alu_res = {{(XLEN-1){1'b0}}, lt_s}; alu_cond = lt_s; end
      OP_SLTU: begin alu_res = {{(XLEN-1){1'b0}}, lt_u}; alu_cond = lt_u; end
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_BEQ:  alu_cond = eq;
      OP_BNE:  alu_cond = !eq;
      OP_BGE:  alu_cond = !lt_s;
      OP_BGEU: alu_cond = !lt_u;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
      default: alu_res = op_a + op_b;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign shift_start = 1'b0;
`else
  logic [3:0]      ctrl_q;
  logic [4:0]      cnt;
  logic [XLEN-1:0] shift_step;

  assign shift_start = accept && (alu_ctrl inside {OP_SLL, OP_SRL, OP_SRA}) && (shamt != 5'd0);

  always_comb begin
    case (ctrl_q)
      OP_SLL:  shift_step = {result[XLEN-2:0], 1'b0};
      OP_SRA:  shift_step = {result[XLEN-1], result[XLEN-1:1]};
      default: shift_step = {1'b0, result[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) && !reset;
    out_valid  = (state == DONE);
    case (state)
      IDLE:    if (accept) state_next = shift_start ? SHIFT : DONE;
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT:   if (cnt == 5'd1) state_next = DONE;
`endif
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The result register doubles as the serial shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      cond   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      ctrl_q <= '0;
      cnt    <= '0;
`endif
    end else if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      ctrl_q <= alu_ctrl;
      cnt    <= shamt;
`endif
      if (shift_start) begin
        result <= op_a;
        cond   <= 1'b0;
      end else begin
        result <= alu_res;
        cond   <= alu_cond;
      end
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (state == SHIFT) begin
      result <= shift_step;
      cnt    <= cnt - 5'd1;
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases, random ops, backpressure, mid-op reset.
// Build with ALU_BARREL_SHIFT_EN defined to expect single-cycle shifts.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cond;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cond      (cond)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: shifts done as repeated single-bit moves.
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic rc);
    logic lts, ltu;
    lts = $signed(a) < $signed(b);
    ltu = a < b;
    r   = 32'h0;
    rc  = 1'b0;
    case (c)
      4'h1: r = a - b;
      4'h2: begin r = a; for (int k = 0; k < int'(b[4:0]); k++) r = r << 1; end
      4'h3: begin r = lts ? 32'd1 : 32'd0; rc = lts; end
      4'h4: begin r = ltu ? 32'd1 : 32'd0; rc = ltu; end
      4'h5: r = a ^ b;
      4'h6: begin r = a; for (int k = 0; k < int'(b[4:0]); k++) r = {a[31], r[31:1]}; end
      4'h7: begin r = a; for (int k = 0; k < int'(b[4:0]); k++) r = r >> 1; end
      4'h8: r = a | b;
      4'h9: r = a & b;
      4'hA: rc = (a == b);
      4'hB: rc = (a != b);
      4'hC: rc = !lts;
      4'hD: rc = !ltu;
      default: r = a + b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((c == 4'h2 || c == 4'h6 || c == 4'h7) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Drive one request, push its expectation, return just after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    e.res = er;
    e.c   = ec;
    e.lat = exp_lat(c, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic send_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        rc;
    ref_alu(c, a, b, r, rc);
    send(c, a, b, r, rc);
  endtask

  // Wait for out_valid, compare against the scoreboard head, optionally hold off out_ready.
  task automatic receive(input bit pre_ready, input int hold);
    exp_t e;
    int   lat = 0;
    out_ready = pre_ready && (hold == 0);
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    e = sb.pop_front();
    check("out_valid", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(e.lat));
    check("result", result, e.res);
    check("cond", 32'(cond), 32'(e.c));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      alu_ctrl = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      @(negedge clk);
      check("bp_result", result, e.res);
      check("bp_cond", 32'(cond), 32'(e.c));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_ack_out_valid", 32'(out_valid), 32'd0);
    check("post_ack_in_ready", 32'(in_ready), 32'd1);
    if (hold > 0) begin
      @(negedge clk);
      check("bp_no_ghost", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 4'h0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_cond", 32'(cond), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    send(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1'b0);       receive(1'b0, 0);
    send(4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);               receive(1'b1, 0);
    send(4'h3, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);               receive(1'b0, 0);
    send(4'h4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);               receive(1'b0, 0);
    send(4'hC, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);               receive(1'b1, 0);
    send(4'hD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);               receive(1'b0, 0);
    send(4'hA, 32'h1234, 32'h1234, 32'h0, 1'b1);                 receive(1'b0, 0);
    send(4'h6, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);      receive(1'b0, 0);
    send(4'h2, 32'h8000_0021, 32'h25, 32'h0000_0420, 1'b0);      receive(1'b1, 0);
    send(4'h7, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);       receive(1'b0, 0);
    send(4'h2, 32'h1, 32'd31, 32'h8000_0000, 1'b0);              receive(1'b1, 0);
    send(4'h7, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 1'b0); receive(1'b0, 0);

    // Backpressure: 10 held cycles with new requests offered and ignored.
    send(4'h5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    receive(1'b0, 10);

    for (int i = 0; i < 24; i++) begin
      send_model(4'($urandom_range(0, 15)), $urandom, $urandom);
      receive(1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of a 20-bit srl aborts it.
    send(4'h7, 32'hFFFF_0000, 32'd20, 32'h0000_0FFF, 1'b0);
    void'(sb.pop_back());
    repeat (5) @(negedge clk);
    check("mid_shift_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_cond", 32'(cond), 32'd0);
    check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    send(4'h0, 32'd2, 32'd3, 32'd5, 1'b0);
    receive(1'b0, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
